// File: rtl/rsa_rfid_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rsa_rfid_pkg
//  Description : Definitions shared by the RSA RFID byte-link blocks
//                (send_data / recv_data): word geometry, byte order and
//                receiver state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package rsa_rfid_pkg;

    // Word geometry of the link.
    localparam int WORD_BYTES = 4;
    localparam int BYTE_W     = 8;

    // Byte order on the wire: the first byte carried is the most significant
    // byte of the cipher word. The transmitter and receiver must agree.
    localparam bit MSB_FIRST  = 1'b1;

    // Receiver state encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LAT  = 2'd2,
        DONE = 2'd3
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/recv_data_gap_timer.sv
`default_nettype none
// ============================================================================
//  Module      : gap_timer
//  Description : 16-bit saturating gap counter. Counts cycles spent waiting
//                for a byte; 'expire' flags that the current wait cycle is
//                the last one allowed.
//  Ports       : clock  - rising-edge clock
//                reset  - asynchronous active-low reset
//                clr    - restart the count at zero (priority over en)
//                en     - count one more empty cycle
//                expire - count has reached GAP_TIMEOUT-1
//  Revision    : 1.0 - initial release
// ============================================================================
module gap_timer #(
    parameter int GAP_TIMEOUT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [15:0] LIMIT = 16'(GAP_TIMEOUT - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != 16'hFFFF)) begin
            // Saturate rather than wrap so a stuck enable can never re-arm.
            cnt_d = cnt_q + 16'd1;
        end
    end

    // The count equals N-1 during the N-th consecutive empty cycle, so this
    // flags the GAP_TIMEOUT-th empty cycle.
    assign expire = (cnt_q >= LIMIT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/recv_data.sv
`default_nettype none
// ============================================================================
//  Module      : recv_data
//  Description : Byte-to-word receiver. On 'start' pops WORD_BYTES bytes from
//                a FIFO with one-cycle read latency, assembles them with the
//                first byte most significant, and pulses 'done'. A per-byte
//                gap timer aborts a stalled word with a 'timeout' pulse.
//  Ports       : clock      - rising-edge clock
//                reset      - asynchronous active-low reset
//                start      - request one word (sampled in IDLE only)
//                fifo_q     - FIFO read data, valid the cycle after req_rd
//                fifo_empty - FIFO empty flag
//                req_rd     - FIFO read request, one cycle per byte
//                data_out   - last completed word
//                done       - one-cycle pulse, data_out just updated
//                busy       - receiver not idle
//                timeout    - one-cycle pulse, word aborted on byte gap
//  Revision    : 1.0 - initial release
// ============================================================================
module recv_data #(
    parameter int WORD_BYTES  = rsa_rfid_pkg::WORD_BYTES,
    parameter int GAP_TIMEOUT = 1024
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [7:0]                fifo_q,
    input  logic                      fifo_empty,
    output logic                      req_rd,
    output logic [8*WORD_BYTES-1:0]   data_out,
    output logic                      done,
    output logic                      busy,
    output logic                      timeout
);

    import rsa_rfid_pkg::*;

    localparam int              WORD_W    = 8 * WORD_BYTES;
    localparam int              CNT_W     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(WORD_BYTES - 1);

    rx_state_e          state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [WORD_W-1:0]  shreg_q,   shreg_d;
    logic [WORD_W-1:0]  data_q,    data_d;
    logic               timeout_q, timeout_d;

    logic               gap_clr;
    logic               gap_en;
    logic               gap_expire;

    logic [WORD_W-1:0]  shreg_in;

    gap_timer #(
        .GAP_TIMEOUT (GAP_TIMEOUT)
    ) u_gap_timer (
        .clock  (clock),
        .reset  (reset),
        .clr    (gap_clr),
        .en     (gap_en),
        .expire (gap_expire)
    );

    // Shift the new byte in so the first byte ends up at the top of the word.
    always_comb begin
        if (MSB_FIRST) begin
            shreg_in = (shreg_q << BYTE_W) | WORD_W'(fifo_q);
        end else begin
            shreg_in = (shreg_q >> BYTE_W) | (WORD_W'(fifo_q) << (WORD_W - BYTE_W));
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        timeout_d = 1'b0;
        gap_clr   = 1'b0;
        gap_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    cnt_d   = '0;
                    shreg_d = '0;
                    gap_clr = 1'b1;
                end
            end
            REQ: begin
                // A byte becoming available takes priority over an expiring
                // gap in the same cycle.
                if (!fifo_empty) begin
                    state_d = LAT;
                    gap_clr = 1'b1;
                end else if (gap_expire) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    gap_en = 1'b1;
                end
            end
            LAT: begin
                shreg_d = shreg_in;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BYTE) begin
                    data_d  = shreg_in;
                    state_d = DONE;
                end else begin
                    state_d = REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            timeout_q <= timeout_d;
        end
    end

    // Read request is combinational so it can never be raised on an empty FIFO.
    assign req_rd   = (state_q == REQ) && !fifo_empty;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign timeout  = timeout_q;
    assign data_out = data_q;

endmodule
`default_nettype wire

// File: tb/tb_recv_data.sv
`default_nettype none
// ============================================================================
//  Module      : tb_recv_data
//  Description : Self-checking bench for recv_data with a bench-side FIFO
//                (one-cycle read latency), a transaction-level reference
//                model checked every cycle, and directed scenarios with
//                hand-computed latencies and words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_recv_data;

    localparam int GAP = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  fifo_q = 8'h00;
    logic        fifo_empty;
    logic        req_rd;
    logic [31:0] data_out;
    logic        done;
    logic        busy;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    recv_data #(
        .WORD_BYTES  (4),
        .GAP_TIMEOUT (GAP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .fifo_q     (fifo_q),
        .fifo_empty (fifo_empty),
        .req_rd     (req_rd),
        .data_out   (data_out),
        .done       (done),
        .busy       (busy),
        .timeout    (timeout)
    );

    // ---------------- bench FIFO: writes from stimulus, reads from DUT -------
    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clock) begin
        if (req_rd) begin
            fifo_q <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 8'd1;
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr      = wr_ptr + 8'd1;
    endtask

    // Transmit-side stand-in: a cipher word goes onto the link first byte MSB.
    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            push(w[8*i +: 8]);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (word-level receive transaction) -------
    // A word is "need" bytes still to fetch; a fetched byte is "in flight" for
    // one cycle before it lands; after the last byte lands the result is shown
    // for one cycle. Waiting on an empty FIFO for GAP cycles abandons the word.
    logic        m_active   = 1'b0;
    logic        m_inflight = 1'b0;
    logic        m_done     = 1'b0;
    logic        m_to       = 1'b0;
    int          m_need     = 0;
    int          m_gap      = 0;
    logic [7:0]  m_rd       = 8'd0;
    logic [7:0]  m_byte     = 8'd0;
    logic [31:0] m_word     = 32'd0;
    logic [31:0] m_out      = 32'd0;
    logic        exp_req;

    assign exp_req = m_active && !m_inflight && !m_done && (m_need > 0) && !fifo_empty;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_active   <= 1'b0;
            m_inflight <= 1'b0;
            m_done     <= 1'b0;
            m_to       <= 1'b0;
            m_need     <= 0;
            m_gap      <= 0;
            m_word     <= 32'd0;
            m_out      <= 32'd0;
        end else begin
            m_to <= 1'b0;
            if (!m_active) begin
                if (start) begin
                    m_active <= 1'b1;
                    m_need   <= 4;
                    m_gap    <= 0;
                    m_word   <= 32'd0;
                end
            end else if (m_done) begin
                m_done   <= 1'b0;
                m_active <= 1'b0;
            end else if (m_inflight) begin
                m_inflight <= 1'b0;
                m_word     <= (m_word * 256) + {24'd0, m_byte};
                if (m_need == 0) begin
                    m_out  <= (m_word * 256) + {24'd0, m_byte};
                    m_done <= 1'b1;
                end
            end else if (!fifo_empty) begin
                m_byte     <= mem[m_rd];
                m_rd       <= m_rd + 8'd1;
                m_need     <= m_need - 1;
                m_inflight <= 1'b1;
                m_gap      <= 0;
            end else if (m_gap == GAP - 1) begin
                m_active <= 1'b0;
                m_to     <= 1'b1;
            end else begin
                m_gap <= m_gap + 1;
            end
        end
    end

    // ---------------- per-cycle compare and event counters -------------------
    int n_req  = 0;
    int n_done = 0;
    int n_to   = 0;
    int n_viol = 0;

    always begin
        @(negedge clock);
        #2;
        if (req_rd)  n_req++;
        if (done)    n_done++;
        if (timeout) n_to++;
        if (req_rd && (fifo_empty || !busy)) n_viol++;
        check("cyc_busy",     {31'd0, busy},    {31'd0, m_active});
        check("cyc_req_rd",   {31'd0, req_rd},  {31'd0, exp_req});
        check("cyc_done",     {31'd0, done},    {31'd0, m_done});
        check("cyc_timeout",  {31'd0, timeout}, {31'd0, m_to});
        check("cyc_data_out", data_out,         m_out);
    end

    // Pulse start at the current negedge and count edges until done/timeout.
    // lat = k means the result became visible after the k-th edge past the
    // edge that sampled start.
    task automatic run_word(output int lat, output bit got_done, output bit got_to,
                            input int budget);
        int k;
        got_done = 1'b0;
        got_to   = 1'b0;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        k     = 0;
        while (k < budget) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (timeout) begin
                got_to = 1'b1;
                break;
            end
            @(negedge clock);
            k++;
        end
        lat = k;
    endtask

    // ---------------- directed scenarios -------------------------------------
    initial begin
        int lat;
        bit gd;
        bit gt;
        int r0;
        int d0;
        int t0;
        logic [7:0] t2 [4];

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        t2[0] = 8'hAA; t2[1] = 8'hBB; t2[2] = 8'hCC; t2[3] = 8'hDD;

        // Reset state.
        repeat (3) @(negedge clock);
        check("rst_busy",     {31'd0, busy},    32'd0);
        check("rst_req_rd",   {31'd0, req_rd},  32'd0);
        check("rst_done",     {31'd0, done},    32'd0);
        check("rst_timeout",  {31'd0, timeout}, 32'd0);
        check("rst_data_out", data_out,         32'h0);
        reset = 1'b1;
        @(negedge clock);

        // 1: FIFO preloaded, no stalls -> 8-cycle latency.
        push(8'h1E); push(8'h34); push(8'h70); push(8'hFB);
        r0 = n_req; t0 = n_to;
        run_word(lat, gd, gt, 40);
        check("t1_done",    {31'd0, gd}, 32'd1);
        check("t1_latency", lat,         32'd8);
        check("t1_data",    data_out,    32'h1E3470FB);
        @(negedge clock);
        check("t1_busy_after", {31'd0, busy}, 32'd0);
        check("t1_reads",      n_req - r0,    32'd4);
        check("t1_no_timeout", n_to - t0,     32'd0);

        // 2: FIFO empty at start, bytes arrive 5 cycles apart.
        fork
            run_word(lat, gd, gt, 60);
            begin
                for (int i = 0; i < 4; i++) begin
                    repeat (5) @(negedge clock);
                    push(t2[i]);
                end
            end
        join
        check("t2_done",    {31'd0, gd}, 32'd1);
        check("t2_latency", lat,         32'd21);
        check("t2_data",    data_out,    32'hAABBCCDD);
        @(negedge clock);
        check("t2_busy_after", {31'd0, busy}, 32'd0);

        // 3: only two bytes -> timeout after GAP empty cycles, word kept.
        push(8'h12); push(8'h34);
        d0 = n_done;
        run_word(lat, gd, gt, 60);
        check("t3_timeout", {31'd0, gt}, 32'd1);
        check("t3_latency", lat,         32'd20);
        check("t3_data",    data_out,    32'hAABBCCDD);
        @(negedge clock);
        check("t3_busy_after", {31'd0, busy}, 32'd0);
        check("t3_no_done",    n_done - d0,   32'd0);

        // 4: second start while busy is ignored.
        push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
        r0 = n_req; d0 = n_done; t0 = n_to;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (40) @(negedge clock);
        check("t4_reads",    n_req - r0,  32'd4);
        check("t4_dones",    n_done - d0, 32'd1);
        check("t4_timeouts", n_to - t0,   32'd0);
        check("t4_data",     data_out,    32'hA1B2C3D4);

        // 5: reset asserted during the latency cycle of byte 3.
        push(8'h99); push(8'h98); push(8'h97);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        check("t5_busy_in_lat", {31'd0, busy}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("t5_rst_req_rd", {31'd0, req_rd}, 32'd0);
        check("t5_rst_busy",   {31'd0, busy},   32'd0);
        check("t5_rst_data",   data_out,        32'h0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        run_word(lat, gd, gt, 40);
        check("t5_latency", lat,      32'd8);
        check("t5_data",    data_out, 32'h11223344);
        @(negedge clock);

        // 6: byte arrives in what would have been the expiring cycle.
        fork
            run_word(lat, gd, gt, 60);
            begin
                repeat (16) @(negedge clock);
                push(8'h5A); push(8'hC3); push(8'h0F); push(8'hE1);
            end
        join
        check("t6_no_timeout", {31'd0, gt}, 32'd0);
        check("t6_latency",    lat,         32'd23);
        check("t6_data",       data_out,    32'h5AC30FE1);
        @(negedge clock);

        // 7: loopback of a transmitted cipher word.
        send_word(32'h1E3470FB);
        run_word(lat, gd, gt, 40);
        check("t7_done", {31'd0, gd}, 32'd1);
        check("t7_data", data_out,    32'h1E3470FB);

        repeat (3) @(negedge clock);
        check("req_while_empty_or_idle", n_viol, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
